// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin front end that serialises client requests onto
// the sdram_controller command interface, one transaction outstanding at a time.
// Read beats and completion are routed back to the owning port, and a watchdog
// aborts a transaction the controller never completes.
// Optional build macro SDRAM_ARB_PRIORITY_EN: port 0 always wins; the other ports
// round-robin among themselves.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no transaction; grant the next requester (combinational ready)
// ST_ISSUE  | drive the latched command to the controller for one cycle
// ST_WAIT_RD| collect BURST_LEN read beats, forwarding each to the owner
// ST_WAIT_WR| wait for the controller's write completion
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [NUM_PORTS-1:0]        rsp_done,
    output logic [NUM_PORTS-1:0]        rsp_error,
    output logic [1:0]                  ctrl_command,
    output logic [ADDR_W-1:0]           ctrl_address,
    output logic [DATA_W-1:0]           ctrl_wdata,
    input  logic [DATA_W-1:0]           ctrl_rdata,
    input  logic                        ctrl_read_valid,
    input  logic                        ctrl_write_done
);

    localparam int PTR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RD, ST_WAIT_WR} state_t;

    state_t                 state, state_nxt;
    logic [PTR_W-1:0]       rr_ptr, owner, next_ptr;
    logic                   wr_flag;
    logic [WD_W-1:0]        wdog;
    logic [BC_W-1:0]        beat_cnt;
    logic [NUM_PORTS-1:0]   cand, grant_oh, owner_oh;
    logic [PTR_W-1:0]       grant_idx, hi_idx, lo_idx;
    logic                   hi_found, any_req;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   sel_write;
    logic                   beat_evt, last_beat, wr_evt, expire;

    // Grant selection: lowest requester at/after the pointer, else lowest below it.
    always_comb begin
        cand = req_valid;
`ifdef SDRAM_ARB_PRIORITY_EN
        cand[0] = 1'b0;
`endif
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (cand[p]) begin
                if (PTR_W'(p) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(p);
                end else begin
                    lo_idx = PTR_W'(p);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
`ifdef SDRAM_ARB_PRIORITY_EN
        if (req_valid[0]) grant_idx = '0;
`endif
        grant_oh  = '0;
        owner_oh  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (PTR_W'(p) == grant_idx) begin
                grant_oh[p] = 1'b1;
                sel_addr    = req_addr[p*ADDR_W +: ADDR_W];
                sel_wdata   = req_wdata[p*DATA_W +: DATA_W];
                sel_write   = req_write[p];
            end
            if (PTR_W'(p) == owner) owner_oh[p] = 1'b1;
        end
        any_req = |req_valid;
    end

    // Completion events, watchdog terminal count and post-transaction pointer.
    always_comb begin
        beat_evt  = (state == ST_WAIT_RD) && ctrl_read_valid;
        last_beat = beat_evt && (beat_cnt == BC_W'(BURST_LEN - 1));
        wr_evt    = (state == ST_WAIT_WR) && ctrl_write_done;
        expire    = (TIMEOUT != 0) && (state == ST_WAIT_RD || state == ST_WAIT_WR) &&
                    (wdog == WD_W'(1)) && !beat_evt && !wr_evt;
        if (owner == PTR_W'(NUM_PORTS - 1)) begin
`ifdef SDRAM_ARB_PRIORITY_EN
            next_ptr = PTR_W'(1);
`else
            next_ptr = '0;
`endif
        end else begin
            next_ptr = owner + PTR_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic plus the state-decoded ready and command outputs.
    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        ctrl_command = CMD_NOP;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    req_ready = grant_oh;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ctrl_command = wr_flag ? CMD_WRITE : CMD_READ;
                state_nxt    = wr_flag ? ST_WAIT_WR : ST_WAIT_RD;
            end
            ST_WAIT_RD: if (last_beat || expire) state_nxt = ST_IDLE;
            ST_WAIT_WR: if (wr_evt || expire)    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Request latching, watchdog/beat counters and registered response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= '0;
            rr_ptr       <= '0;
            wr_flag      <= 1'b0;
            ctrl_address <= '0;
            ctrl_wdata   <= '0;
            wdog         <= '0;
            beat_cnt     <= '0;
            rsp_rdata    <= '0;
            rsp_valid    <= '0;
            rsp_done     <= '0;
            rsp_error    <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_done  <= '0;
            rsp_error <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner        <= grant_idx;
                        wr_flag      <= sel_write;
                        ctrl_address <= sel_addr;
                        ctrl_wdata   <= sel_wdata;
                        beat_cnt     <= '0;
                    end
                end
                ST_ISSUE: wdog <= WD_W'(TIMEOUT);
                ST_WAIT_RD, ST_WAIT_WR: begin
                    if (beat_evt) begin
                        rsp_rdata <= ctrl_rdata;
                        rsp_valid <= owner_oh;
                        beat_cnt  <= beat_cnt + BC_W'(1);
                        wdog      <= WD_W'(TIMEOUT);
                    end else if (TIMEOUT != 0 && wdog != '0) begin
                        wdog <= wdog - WD_W'(1);
                    end
                    if (last_beat || wr_evt) begin
                        rsp_done <= owner_oh;
                        rr_ptr   <= next_ptr;
                    end else if (expire) begin
                        rsp_done  <= owner_oh;
                        rsp_error <= owner_oh;
                        rr_ptr    <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (3 ports, 4-beat reads, 16-cycle watchdog)
// with a small controller model that answers commands one cycle later.
module tb_sdram_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int TO = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NP-1:0]       req_valid, req_write, req_ready;
    logic [NP*AW-1:0]    req_addr;
    logic [NP*DW-1:0]    req_wdata;
    logic [DW-1:0]       rsp_rdata, ctrl_wdata, ctrl_rdata;
    logic [NP-1:0]       rsp_valid, rsp_done, rsp_error;
    logic [1:0]          ctrl_command;
    logic [AW-1:0]       ctrl_address;
    logic                ctrl_read_valid, ctrl_write_done;
    logic                model_wd, tb_wd, model_silent;

    int checks = 0;
    int errors = 0;

    localparam logic [AW-1:0] ADDR0 = 22'h01234;
    localparam logic [AW-1:0] ADDR1 = 22'h02468;
    localparam logic [AW-1:0] ADDR2 = 22'h0ACE1;
    localparam logic [DW-1:0] WD1   = 32'hDEADBEEF;

    assign ctrl_write_done = model_wd | tb_wd;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid), .rsp_done(rsp_done),
        .rsp_error(rsp_error), .ctrl_command(ctrl_command),
        .ctrl_address(ctrl_address), .ctrl_wdata(ctrl_wdata),
        .ctrl_rdata(ctrl_rdata), .ctrl_read_valid(ctrl_read_valid),
        .ctrl_write_done(ctrl_write_done)
    );

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
        return {8'hA5, a[19:0], 4'(b)};
    endfunction

    // Controller model: answers READ with BL consecutive beats, WRITE with one done.
    initial begin
        logic [AW-1:0] a;
        ctrl_read_valid = 1'b0;
        ctrl_rdata      = '0;
        model_wd        = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ctrl_command == 2'b10 && !model_silent) begin
                a = ctrl_address;
                for (int b = 0; b < BL; b++) begin
                    @(posedge clk); #1;
                    ctrl_read_valid = 1'b1;
                    ctrl_rdata      = beat_data(a, b);
                end
                @(posedge clk); #1;
                ctrl_read_valid = 1'b0;
            end else if (ctrl_command == 2'b01 && !model_silent) begin
                @(posedge clk); #1;
                model_wd = 1'b1;
                @(posedge clk); #1;
                model_wd = 1'b0;
            end
        end
    end

    task automatic wait_ready(input int p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (req_ready[p]) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_done(input int p, output bit ok, output logic [NP-1:0] err);
        ok  = 1'b0;
        err = '0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (rsp_done[p]) begin
                ok  = 1'b1;
                err = rsp_error;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_done !== '0 || rsp_error !== '0) begin
            errors++;
            $display("FAIL reset_rsp: ready=%b valid=%b done=%b err=%b required all 0",
                     req_ready, rsp_valid, rsp_done, rsp_error);
        end
        checks++;
        if (ctrl_command !== 2'b00) begin
            errors++;
            $display("FAIL reset_cmd: got %b required 00", ctrl_command);
        end
        checks++;
        if (ctrl_address !== '0 || ctrl_wdata !== '0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0",
                     ctrl_address, ctrl_wdata, rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_simultaneous;
        bit ok;
        logic [NP-1:0] err;
        @(posedge clk); #1;
        req_write = '0;
        req_valid = 3'b011;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL sim_first_grant: got %b required 001", req_ready);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checks++;
        if (ctrl_command !== 2'b10 || ctrl_address !== ADDR0) begin
            errors++;
            $display("FAIL sim_issue: cmd=%b addr=%h required 10/%h", ctrl_command, ctrl_address, ADDR0);
        end
        @(posedge clk); #1;
        checks++;
        if (ctrl_command !== 2'b00) begin
            errors++;
            $display("FAIL sim_cmd_one_cycle: got %b required 00", ctrl_command);
        end
        wait_done(0, ok, err);
        checks++;
        if (!ok || rsp_rdata !== beat_data(ADDR0, BL - 1)) begin
            errors++;
            $display("FAIL sim_done0: seen=%0d rdata=%h required 1/%h", ok, rsp_rdata, beat_data(ADDR0, BL - 1));
        end
        wait_ready(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sim_second_grant: port1 ready seen=%0d required 1", ok);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_done(1, ok, err);
        checks++;
        if (!ok || err !== '0) begin
            errors++;
            $display("FAIL sim_done1: seen=%0d err=%b required 1/000", ok, err);
        end
    endtask

    task automatic test_write;
        bit ok;
        @(posedge clk); #1;
        req_write = 3'b010;
        req_valid = 3'b010;
        wait_ready(1, ok);
        @(posedge clk); #1;
        req_valid = '0;
        checks++;
        if (!ok || ctrl_command !== 2'b01 || ctrl_address !== ADDR1 || ctrl_wdata !== WD1) begin
            errors++;
            $display("FAIL wr_issue: ok=%0d cmd=%b addr=%h wdata=%h required 1/01/%h/%h",
                     ok, ctrl_command, ctrl_address, ctrl_wdata, ADDR1, WD1);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_done !== '0) begin
            errors++;
            $display("FAIL wr_early_done: got %b required 000", rsp_done);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_done !== 3'b010 || rsp_valid !== '0 || rsp_error !== '0) begin
            errors++;
            $display("FAIL wr_done: done=%b valid=%b err=%b required 010/000/000",
                     rsp_done, rsp_valid, rsp_error);
        end
        req_write = '0;
    endtask

    task automatic test_burst;
        bit ok;
        bit done_seen;
        int k;
        @(posedge clk); #1;
        req_valid = 3'b100;
        wait_ready(2, ok);
        @(posedge clk); #1;
        req_valid = '0;
        k = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 32 && !done_seen; c++) begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                checks++;
                if (rsp_valid !== 3'b100 || rsp_rdata !== beat_data(ADDR2, k)) begin
                    errors++;
                    $display("FAIL burst_beat%0d: valid=%b data=%h required 100/%h",
                             k, rsp_valid, rsp_rdata, beat_data(ADDR2, k));
                end
                if (rsp_done[2]) begin
                    done_seen = 1'b1;
                    checks++;
                    if (k != BL - 1) begin
                        errors++;
                        $display("FAIL burst_done_beat: done on beat %0d required %0d", k, BL - 1);
                    end
                end
                k++;
            end
        end
        checks++;
        if (!ok || !done_seen || k != BL) begin
            errors++;
            $display("FAIL burst_count: granted=%0d done=%0d beats=%0d required 1/1/%0d", ok, done_seen, k, BL);
        end
    endtask

    task automatic grant_sequence(input logic [NP-1:0] valid, input int n_exp,
                                  input int exp[9], input string name);
        int log_q[$];
        bit ok;
        logic [NP-1:0] err;
        @(posedge clk); #1;
        req_valid = valid;
        for (int c = 0; c < 400 && log_q.size() < n_exp; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) if (req_ready[p]) log_q.push_back(p);
        end
        @(posedge clk); #1;
        req_valid = '0;
        checks++;
        if (log_q.size() != n_exp) begin
            errors++;
            $display("FAIL %s_count: got %0d grants required %0d", name, log_q.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] != exp[i]) begin
                errors++;
                $display("FAIL %s_grant%0d: got port %0d required port %0d", name, i, log_q[i], exp[i]);
            end
        end
        wait_done(exp[n_exp-1], ok, err);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_final_done: seen %0d required 1", name, ok);
        end
    endtask

    task automatic test_round_robin;
`ifdef SDRAM_ARB_PRIORITY_EN
        int exp[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        int exp[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif
        req_write = 3'b010;
        grant_sequence(3'b111, 9, exp, "rr");
        req_write = '0;
    endtask

    task automatic test_expiry_race;
        bit early;
        bit ok;
        model_silent = 1'b1;
        early = 1'b0;
        @(posedge clk); #1;
        req_write = 3'b100;
        req_valid = 3'b100;
        wait_ready(2, ok);
        @(posedge clk); #1;
        req_valid = '0;
        for (int n = 1; n <= TO; n++) begin
            @(posedge clk); #1;
            if (rsp_done !== '0) early = 1'b1;
        end
        tb_wd = 1'b1;
        @(posedge clk); #1;
        tb_wd = 1'b0;
        checks++;
        if (!ok || early || rsp_done !== 3'b100 || rsp_error !== '0) begin
            errors++;
            $display("FAIL race_done_wins: early=%0d done=%b err=%b required 0/100/000",
                     early, rsp_done, rsp_error);
        end
        model_silent = 1'b0;
        req_write = '0;
    endtask

    task automatic test_timeout;
        bit ok;
        int first;
        logic [NP-1:0] got_done, got_err, err;
        model_silent = 1'b1;
        @(posedge clk); #1;
        req_valid = 3'b010;
        wait_ready(1, ok);
        @(posedge clk); #1;
        req_valid = '0;
        first = -1;
        got_done = '0;
        got_err  = '0;
        for (int n = 1; n <= 30 && first < 0; n++) begin
            @(posedge clk); #1;
            if (rsp_done !== '0) begin
                first    = n;
                got_done = rsp_done;
                got_err  = rsp_error;
            end
        end
        checks++;
        if (!ok || first != TO + 1) begin
            errors++;
            $display("FAIL to_latency: done %0d cycles after issue required %0d", first, TO + 1);
        end
        checks++;
        if (got_done !== 3'b010 || got_err !== 3'b010) begin
            errors++;
            $display("FAIL to_flags: done=%b err=%b required 010/010", got_done, got_err);
        end
        model_silent = 1'b0;
        @(posedge clk); #1;
        req_valid = 3'b001;
        wait_ready(0, ok);
        @(posedge clk); #1;
        req_valid = '0;
        wait_done(0, ok, err);
        checks++;
        if (!ok || err !== '0) begin
            errors++;
            $display("FAIL to_next_request: seen=%0d err=%b required 1/000", ok, err);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit spurious;
        int beats;
        logic [NP-1:0] err;
        @(posedge clk); #1;
        req_valid = 3'b100;
        wait_ready(2, ok);
        @(posedge clk); #1;
        req_valid = '0;
        beats = 0;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            @(negedge clk);
            if (rsp_valid[2]) beats++;
        end
        checks++;
        if (!ok || beats != 2) begin
            errors++;
            $display("FAIL rst_mid_setup: granted=%0d beats=%0d required 1/2", ok, beats);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== '0 || rsp_done !== '0 || ctrl_command !== 2'b00 ||
            rsp_rdata !== '0 || ctrl_address !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: valid=%b done=%b cmd=%b rdata=%h addr=%h required all 0",
                     rsp_valid, rsp_done, ctrl_command, rsp_rdata, ctrl_address);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_done !== '0 || rsp_valid !== '0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL rst_mid_silent: response after reset seen=%0d required 0", spurious);
        end
        @(posedge clk); #1;
        req_valid = 3'b101;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid_next_grant: got %b required 001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_done(0, ok, err);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_next_done: seen %0d required 1", ok);
        end
    endtask

    task automatic test_contention;
`ifdef SDRAM_ARB_PRIORITY_EN
        int exp[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        int exp[9] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
`endif
        grant_sequence(3'b011, 4, exp, "contend");
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_write    = '0;
        tb_wd        = 1'b0;
        model_silent = 1'b0;
        req_addr     = {ADDR2, ADDR1, ADDR0};
        req_wdata    = {32'hC0DE0002, WD1, 32'hC0DE0000};
        repeat (3) @(posedge clk);
        test_reset;
        test_simultaneous;
        test_write;
        test_burst;
        test_round_robin;
        test_expiry_race;
        test_timeout;
        test_reset_mid;
        test_contention;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
